// File: rtl/fp_multiplier_seq.sv
// IEEE-754 single multiplier, 24-cycle shift-add mantissa, truncating; accept-to-out_valid = 25 edges, handshake on the 26th.
// One operation in flight: in_ready only in IDLE, result/flags held in DONE until out_ready.
module fp_multiplier_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            overflow,
  output logic            underflow,
  output logic            exception
);

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_sign;
  logic [7:0]  r_ea;
  logic [7:0]  r_eb;
  logic [23:0] r_ma;
  logic [23:0] r_mb;
  logic [47:0] r_p;
  logic [4:0]  r_cnt;
  logic [31:0] r_result;
  logic        r_ovf;
  logic        r_unf;
  logic        r_exc;

  logic [9:0]  w_exp_sum;
  logic [9:0]  w_exp;
  logic [22:0] w_mant;
  logic [31:0] w_res;
  logic        w_ovf;
  logic        w_unf;
  logic        w_exc;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)        w_state_nxt = MUL;
      MUL:     if (r_cnt == 5'd23)  w_state_nxt = NORM;
      NORM:                         w_state_nxt = DONE;
      DONE:    if (out_ready)       w_state_nxt = IDLE;
      default:                      w_state_nxt = IDLE;
    endcase
  end

  // Exponent kept as 10-bit two's complement so both overflow and underflow are visible.
  always_comb begin
    w_exp_sum = {2'b00, r_ea} + {2'b00, r_eb} - 10'd127;
    w_exp     = w_exp_sum + {9'd0, r_p[47]};
    w_mant    = r_p[47] ? r_p[46:24] : r_p[45:23];
    w_res     = {r_sign, w_exp[7:0], w_mant};
    w_ovf     = 1'b0;
    w_unf     = 1'b0;
    w_exc     = 1'b0;
    if (r_ea == 8'hFF || r_eb == 8'hFF) begin
      w_exc = 1'b1;
      w_res = {r_sign, 8'hFF, 23'h400000};
    end else if (r_ea == 8'h00 || r_eb == 8'h00) begin
      w_res = {r_sign, 31'd0};
    end else if ($signed(w_exp) >= 10'sd255) begin
      w_ovf = 1'b1;
      w_res = {r_sign, 8'hFF, 23'd0};
    end else if ($signed(w_exp) <= 10'sd0) begin
      w_unf = 1'b1;
      w_res = {r_sign, 31'd0};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_sign   <= 1'b0;
      r_ea     <= 8'd0;
      r_eb     <= 8'd0;
      r_ma     <= 24'd0;
      r_mb     <= 24'd0;
      r_p      <= 48'd0;
      r_cnt    <= 5'd0;
      r_result <= 32'd0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_exc    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sign <= a[31] ^ b[31];
            r_ea   <= a[30:23];
            r_eb   <= b[30:23];
            r_ma   <= {|a[30:23], a[22:0]};
            r_mb   <= {|b[30:23], b[22:0]};
            r_p    <= 48'd0;
            r_cnt  <= 5'd0;
          end
        end
        MUL: begin
          if (r_mb[0]) r_p <= r_p + ({24'd0, r_ma} << r_cnt);
          r_mb  <= r_mb >> 1;
          r_cnt <= r_cnt + 5'd1;
        end
        NORM: begin
          r_result <= w_res;
          r_ovf    <= w_ovf;
          r_unf    <= w_unf;
          r_exc    <= w_exc;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign overflow  = r_ovf;
  assign underflow = r_unf;
  assign exception = r_exc;

endmodule
